// File: rtl/vga_sync_if.sv
// vga_sync_if: VGA timing bundle driven by the sync generator and sampled
// by every overlay stage on the same clock.
interface vga_sync_if;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       pixel_tick;
    logic       frame_start;
    modport master(output hcount, vcount, hsync, vsync, video_on, pixel_tick, frame_start);
    modport slave(input hcount, vcount, hsync, vsync, video_on, pixel_tick, frame_start);
endinterface

// File: rtl/vga_sync.sv
// vga_sync: 640x480@60 VGA timing generator; pixel/line counters, syncs and
// visible-area flag, all registered together from the next counter values.
module vga_sync #(
    parameter int   CLK_DIV   = 2,
    parameter int   H_VISIBLE = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_VISIBLE = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter logic SYNC_POL  = 1'b0
) (
    input  logic          clock,
    input  logic          reset_n,
    vga_sync_if.master    vga_o
);
    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int DW       = $clog2(CLK_DIV + 1);
    logic [DW-1:0] div_q, div_d;
    logic [9:0]    hcount_q, hcount_d, vcount_q, vcount_d;
    logic          hsync_q, vsync_q, video_on_q;
    logic          tick, h_end, v_end;
    always_comb begin
        tick     = div_q == DW'(CLK_DIV - 1);
        h_end    = hcount_q == 10'(H_TOTAL - 1);
        v_end    = vcount_q == 10'(V_TOTAL - 1);
        div_d    = tick ? '0 : div_q + DW'(1);
        hcount_d = !tick ? hcount_q : h_end ? '0 : hcount_q + 10'd1;
        vcount_d = !(tick && h_end) ? vcount_q : v_end ? '0 : vcount_q + 10'd1;
    end
    // Syncs and video_on track the next counters so they move on the same edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_q      <= '0;
            hcount_q   <= '0;
            vcount_q   <= '0;
            hsync_q    <= ~SYNC_POL;
            vsync_q    <= ~SYNC_POL;
            video_on_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            hcount_q   <= hcount_d;
            vcount_q   <= vcount_d;
            hsync_q    <= (hcount_d >= 10'(HS_START) && hcount_d < 10'(HS_END)) ? SYNC_POL : ~SYNC_POL;
            vsync_q    <= (vcount_d >= 10'(VS_START) && vcount_d < 10'(VS_END)) ? SYNC_POL : ~SYNC_POL;
            video_on_q <= hcount_d < 10'(H_VISIBLE) && vcount_d < 10'(V_VISIBLE);
        end
    end
    assign vga_o.hcount      = hcount_q;
    assign vga_o.vcount      = vcount_q;
    assign vga_o.hsync       = hsync_q;
    assign vga_o.vsync       = vsync_q;
    assign vga_o.video_on    = video_on_q;
    assign vga_o.pixel_tick  = tick;
    assign vga_o.frame_start = tick && hcount_q == '0 && vcount_q == '0;
endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync: directed checks of the default 640x480 timing, a CLK_DIV=1 build
// and a shrunken active-high-sync build that makes whole frames affordable.
module tb_vga_sync;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   t0, n;
    int   fss = 0;
    int   mh2 = 0, mhs = 0, mvs = 0;
    vga_sync_if vga();
    vga_sync_if vga1();
    vga_sync_if vgs();
    vga_sync u_dut (.clock(clock), .reset_n(reset_n), .vga_o(vga));
    vga_sync #(.CLK_DIV(1)) u_dut1 (.clock(clock), .reset_n(reset_n), .vga_o(vga1));
    vga_sync #(.CLK_DIV(2), .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
               .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .SYNC_POL(1'b1))
        u_dut_s (.clock(clock), .reset_n(reset_n), .vga_o(vgs));
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) begin
        if (int'(vga.hcount) > mh2) mh2 <= int'(vga.hcount);
        if (int'(vgs.hcount) > mhs) mhs <= int'(vgs.hcount);
        if (int'(vgs.vcount) > mvs) mvs <= int'(vgs.vcount);
        if (!reset_n) fss <= 0;
        else if (vgs.frame_start) fss <= fss + 1;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clock);
        #1;
    endtask
    function automatic int hc(input bit sm);
        return sm ? int'(vgs.hcount) : int'(vga.hcount);
    endfunction
    function automatic int vc(input bit sm);
        return sm ? int'(vgs.vcount) : int'(vga.vcount);
    endfunction
    task automatic run_to(input bit sm, input int h, input int v, input int limit);
        int k = 0;
        while (!(hc(sm) == h && vc(sm) == v) && k < limit) begin
            step();
            k++;
        end
        check($sformatf("reach_%0d_%0d_%0d", sm, h, v), hc(sm) == h && vc(sm) == v, 1);
    endtask
    task automatic release_checks(input string tag);
        repeat (5) step();
        check({tag, "_rst_h"}, vga.hcount, 0);
        check({tag, "_rst_v"}, vga.vcount, 0);
        check({tag, "_rst_hs"}, vga.hsync, 1);
        check({tag, "_rst_vs"}, vga.vsync, 1);
        check({tag, "_rst_von"}, vga.video_on, 0);
        check({tag, "_rst_tick"}, vga.pixel_tick, 0);
        check({tag, "_rst_s_hs"}, vgs.hsync, 0);
        check({tag, "_rst_s_vs"}, vgs.vsync, 0);
        @(negedge clock);
        reset_n = 1'b1;
        step();
        t0 = cyc;
        check({tag, "_e1_von"}, vga.video_on, 1);
        check({tag, "_e1_tick"}, vga.pixel_tick, 1);
        check({tag, "_e1_fs"}, vga.frame_start, 1);
        check({tag, "_e1_h"}, vga.hcount, 0);
        check({tag, "_e1_d1_h"}, vga1.hcount, 1);
        check({tag, "_e1_d1_tick"}, vga1.pixel_tick, 1);
        step();
        check({tag, "_e2_h"}, vga.hcount, 1);
        check({tag, "_e2_fs"}, vga.frame_start, 0);
    endtask
    initial begin
        release_checks("a");
        run_to(0, 639, 0, 2000);
        check("von_639", vga.video_on, 1);
        step();
        step();
        check("h_640", vga.hcount, 640);
        check("von_640", vga.video_on, 0);
        run_to(0, 655, 0, 100);
        check("hs_655", vga.hsync, 1);
        step();
        step();
        check("hs_656", vga.hsync, 0);
        n = 0;
        while (vga.hsync == 1'b0 && n < 1000) begin
            step();
            n++;
        end
        check("hs_width", n, 192);
        check("hs_end_h", vga.hcount, 752);
        run_to(0, 799, 0, 200);
        step();
        check("tick_799", vga.pixel_tick, 1);
        check("h_799", vga.hcount, 799);
        step();
        check("wrap_h", vga.hcount, 0);
        check("wrap_v", vga.vcount, 1);
        check("d1_h", vga1.hcount, (cyc - t0 + 1) % 800);
        check("d1_v", vga1.vcount, (cyc - t0 + 1) / 800);
        check("d1_tick", vga1.pixel_tick, 1);
        run_to(0, 700, 1, 2000);
        check("hs_700", vga.hsync, 0);
        #2 reset_n = 1'b0;
        #1;
        check("async_h", vga.hcount, 0);
        check("async_v", vga.vcount, 0);
        check("async_hs", vga.hsync, 1);
        check("async_von", vga.video_on, 0);
        check("async_tick", vga.pixel_tick, 0);
        check("max_h", mh2, 799);
        release_checks("b");
        run_to(1, 24, 7, 1000);
        check("s_vs_7", vgs.vsync, 0);
        step();
        step();
        check("s_vs_8", vgs.vsync, 1);
        check("s_vs_8_h", vgs.hcount, 0);
        n = 0;
        while (vgs.vsync == 1'b1 && n < 1000) begin
            step();
            n++;
        end
        check("s_vs_width", n, 100);
        check("s_vs_end_v", vgs.vcount, 10);
        run_to(1, 24, 11, 1000);
        step();
        step();
        check("s_wrap_h", vgs.hcount, 0);
        check("s_wrap_v", vgs.vcount, 0);
        step();
        check("s_fs", vgs.frame_start, 1);
        check("s_frame_len", cyc - t0, 600);
        step();
        check("s_fs_width", vgs.frame_start, 0);
        check("s_fs_count", fss, 2);
        check("s_max_h", mhs, 24);
        check("s_max_v", mvs, 11);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
